p18_multi_sprite_engine: RTL and testbench

//  Parametrised N-sprite generator for the SVGA pipeline. Replaces the single fixed sprite path.

---
 rtl/p18_multi_sprite_engine_pkg.sv | 34 +++
 rtl/p18_multi_sprite_engine_if.sv | 18 +
 rtl/p18_multi_sprite_engine_slot.sv | 124 ++++++++++++
 rtl/p18_multi_sprite_engine.sv | 120 ++++++++++++
 tb/tb_p18_multi_sprite_engine.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/p18_multi_sprite_engine_pkg.sv
// Shared constants and types for the multi-sprite engine.
// Config field addresses are offsets above the bitmap rows (base = SPRITE_H).
// The ctrl word bit positions match the slot_ctrl_t layout.
package p18_sprite_pkg;

    localparam int ADDR_W = 5;    // cfg_addr width
    localparam int POS_W  = 8;    // x/y position register width

    // Field offsets relative to SPRITE_H
    localparam int ADDR_X_OFS     = 0;
    localparam int ADDR_Y_OFS     = 1;
    localparam int ADDR_COLOR_OFS = 2;
    localparam int ADDR_CTRL_OFS  = 3;

    // Ctrl word bit indices
    localparam int CTRL_EN     = 0;
    localparam int CTRL_MOVE   = 1;
    localparam int CTRL_DX_NEG = 2;
    localparam int CTRL_DY_NEG = 3;

    // Packed MSB-first so that bit 0 is the enable flag
    typedef struct packed {
        logic dy_neg;
        logic dx_neg;
        logic move;
        logic en;
    } slot_ctrl_t;

    // Slot-select width, never narrower than one bit
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/p18_multi_sprite_engine_if.sv
// Config write bus: valid/ready handshake carrying slot select, field address and data.
//   master: valid, sel, addr, data out; ready in
//   slave : valid, sel, addr, data in;  ready out
interface p18_multi_sprite_engine_if
    import p18_sprite_pkg::*;
#(
    parameter int SEL_W  = 2,
    parameter int DATA_W = 12
);
    logic              valid;
    logic              ready;
    logic [SEL_W-1:0]  sel;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;

    modport master (output valid, sel, addr, data, input ready);
    modport slave  (input valid, sel, addr, data, output ready);
endinterface

// File: rtl/p18_multi_sprite_engine_slot.sv
// One sprite slot: bitmap, live/shadow position, colour and ctrl registers,
// per-frame bounce movement and a combinational opaque flag for the current pixel.
//   clk, reset_n           clock, synchronous active-low reset
//   i_wr/i_addr/i_data     accepted config write aimed at this slot
//   i_next_frame           end-of-frame pulse (shadow copy + movement)
//   i_move_en              global movement enable
//   i_active               visible-region flag
//   i_hs/i_vs              current scaled pixel coordinates
//   o_opaque, o_color      opaque pixel flag and slot colour
module p18_sprite_slot
    import p18_sprite_pkg::*;
#(
    parameter int IDX          = 0,
    parameter int SPRITE_W     = 12,
    parameter int SPRITE_H     = 12,
    parameter int CW           = 9,
    parameter int WIDTH_SMALL  = 100,
    parameter int HEIGHT_SMALL = 75,
    parameter int COLOR_BITS   = 6,
    parameter int DATA_W       = 12
)(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_wr,
    input  logic [ADDR_W-1:0]     i_addr,
    input  logic [DATA_W-1:0]     i_data,
    input  logic                  i_next_frame,
    input  logic                  i_move_en,
    input  logic                  i_active,
    input  logic [CW-1:0]         i_hs,
    input  logic [CW-1:0]         i_vs,
    output logic                  o_opaque,
    output logic [COLOR_BITS-1:0] o_color
);
    localparam int RW = $clog2(SPRITE_H);
    localparam int BW = $clog2(SPRITE_W);
    localparam logic [POS_W-1:0] X_RST = POS_W'(8 + 16 * IDX);
    localparam logic [POS_W-1:0] Y_RST = POS_W'(8 + 8 * IDX);
    localparam logic [POS_W-1:0] X_MAX = POS_W'(WIDTH_SMALL - SPRITE_W);
    localparam logic [POS_W-1:0] Y_MAX = POS_W'(HEIGHT_SMALL - SPRITE_H);

    logic [SPRITE_W-1:0]   r_bitmap [SPRITE_H];
    logic [POS_W-1:0]      r_x, r_y, r_sh_x, r_sh_y;
    logic [COLOR_BITS-1:0] r_color;
    slot_ctrl_t            r_ctrl;

    logic [POS_W-1:0]      w_nx, w_ny;
    logic                  w_dx_neg, w_dy_neg;
    logic [CW-1:0]         w_x, w_y;
    logic [BW-1:0]         w_dh;
    logic [RW-1:0]         w_dv;
    logic                  w_in_h, w_in_v;
    logic [SPRITE_W-1:0]   w_row, w_shift;

    // Next position starts from the shadow copy; at an edge the direction
    // flips and the position holds for that frame.
    always_comb begin
        w_nx     = r_sh_x;
        w_ny     = r_sh_y;
        w_dx_neg = r_ctrl.dx_neg;
        w_dy_neg = r_ctrl.dy_neg;
        if (i_move_en && r_ctrl.en && r_ctrl.move) begin
            if (r_ctrl.dx_neg) begin
                if (r_sh_x == '0) w_dx_neg = 1'b0;
                else              w_nx     = r_sh_x - 1'b1;
            end else begin
                if (r_sh_x == X_MAX) w_dx_neg = 1'b1;
                else                 w_nx     = r_sh_x + 1'b1;
            end
            if (r_ctrl.dy_neg) begin
                if (r_sh_y == '0) w_dy_neg = 1'b0;
                else              w_ny     = r_sh_y - 1'b1;
            end else begin
                if (r_sh_y == Y_MAX) w_dy_neg = 1'b1;
                else                 w_ny     = r_sh_y + 1'b1;
            end
        end
    end

    // Config writes are never accepted during next_frame, so the branches are exclusive.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_bitmap <= '{default: '0};
            r_x      <= X_RST;
            r_y      <= Y_RST;
            r_sh_x   <= X_RST;
            r_sh_y   <= Y_RST;
            r_color  <= '1;
            r_ctrl   <= '0;
        end else if (i_next_frame) begin
            r_x           <= w_nx;
            r_y           <= w_ny;
            r_sh_x        <= w_nx;
            r_sh_y        <= w_ny;
            r_ctrl.dx_neg <= w_dx_neg;
            r_ctrl.dy_neg <= w_dy_neg;
        end else if (i_wr) begin
            if (i_addr < ADDR_W'(SPRITE_H))
                r_bitmap[i_addr[RW-1:0]] <= i_data[SPRITE_W-1:0];
            else if (i_addr == ADDR_W'(SPRITE_H + ADDR_X_OFS))
                r_sh_x <= i_data[POS_W-1:0];
            else if (i_addr == ADDR_W'(SPRITE_H + ADDR_Y_OFS))
                r_sh_y <= i_data[POS_W-1:0];
            else if (i_addr == ADDR_W'(SPRITE_H + ADDR_COLOR_OFS))
                r_color <= i_data[COLOR_BITS-1:0];
            else if (i_addr == ADDR_W'(SPRITE_H + ADDR_CTRL_OFS))
                r_ctrl <= slot_ctrl_t'(i_data[CTRL_DY_NEG:CTRL_EN]);
        end
    end

    // Bounds compared one bit wider than the scaled counter so x+SPRITE_W cannot wrap.
    assign w_x    = CW'(r_x);
    assign w_y    = CW'(r_y);
    assign w_dh   = BW'(i_hs - w_x);
    assign w_dv   = RW'(i_vs - w_y);
    assign w_in_h = (i_hs >= w_x) && (i_hs < w_x + CW'(SPRITE_W));
    assign w_in_v = (i_vs >= w_y) && (i_vs < w_y + CW'(SPRITE_H));
    // Shift the row so the addressed column (MSB = leftmost) lands in the top bit
    assign w_row    = r_bitmap[w_dv];
    assign w_shift  = w_row << w_dh;
    assign o_opaque = i_active && r_ctrl.en && w_in_h && w_in_v && w_shift[SPRITE_W-1];
    assign o_color  = r_color;

endmodule

// File: rtl/p18_multi_sprite_engine.sv
// N-slot sprite generator: per-slot hit test, lowest-index priority compositing,
// registered pixel outputs and a per-frame collision mask.
//   clk, reset_n            pixel clock, synchronous active-low reset
//   active, counter_h/v     visible flag and screen coordinates
//   next_frame              end-of-frame pulse
//   enable_movement         global motion enable, sampled at next_frame
//   cfg                     config write bus (slave)
//   sprite_hit/color/id     winning opaque sprite, one clock after the counters
//   collision               per-sprite collision flags of the last complete frame
module p18_multi_sprite_engine
    import p18_sprite_pkg::*;
#(
    parameter int NUM_SPRITES  = 4,
    parameter int SPRITE_W     = 12,
    parameter int SPRITE_H     = 12,
    parameter int SCALE_LOG2   = 3,
    parameter int CNT_BITS     = 11,
    parameter int WIDTH_SMALL  = 100,
    parameter int HEIGHT_SMALL = 75,
    parameter int COLOR_BITS   = 6,
    localparam int SEL_W       = sel_width(NUM_SPRITES)
)(
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    active,
    input  logic [CNT_BITS-1:0]     counter_h,
    input  logic [CNT_BITS-1:0]     counter_v,
    input  logic                    next_frame,
    input  logic                    enable_movement,
    p18_multi_sprite_engine_if.slave cfg,
    output logic                    sprite_hit,
    output logic [COLOR_BITS-1:0]   sprite_color,
    output logic [SEL_W-1:0]        sprite_id,
    output logic [NUM_SPRITES-1:0]  collision
);
    localparam int HS_W = CNT_BITS - SCALE_LOG2 + 1;

    logic [HS_W-1:0]                        w_hs, w_vs;
    logic [NUM_SPRITES-1:0]                 w_wr, w_opaque, w_coll_now;
    logic [NUM_SPRITES-1:0][COLOR_BITS-1:0] w_colors;
    logic                                   w_hit;
    logic [COLOR_BITS-1:0]                  w_color;
    logic [SEL_W-1:0]                       w_id;
    logic [NUM_SPRITES-1:0]                 r_mask;

    // Stall writes during next_frame so shadow x/y never race the frame update
    assign cfg.ready = !next_frame;

    assign w_hs = HS_W'(counter_h >> SCALE_LOG2);
    assign w_vs = HS_W'(counter_v >> SCALE_LOG2);

    for (genvar i = 0; i < NUM_SPRITES; i++) begin : g_slot
        assign w_wr[i] = cfg.valid && !next_frame && (cfg.sel == SEL_W'(i));

        p18_sprite_slot #(
            .IDX          (i),
            .SPRITE_W     (SPRITE_W),
            .SPRITE_H     (SPRITE_H),
            .CW           (HS_W),
            .WIDTH_SMALL  (WIDTH_SMALL),
            .HEIGHT_SMALL (HEIGHT_SMALL),
            .COLOR_BITS   (COLOR_BITS),
            .DATA_W       ($bits(cfg.data))
        ) u_slot (
            .clk          (clk),
            .reset_n      (reset_n),
            .i_wr         (w_wr[i]),
            .i_addr       (cfg.addr),
            .i_data       (cfg.data),
            .i_next_frame (next_frame),
            .i_move_en    (enable_movement),
            .i_active     (active),
            .i_hs         (w_hs),
            .i_vs         (w_vs),
            .o_opaque     (w_opaque[i]),
            .o_color      (w_colors[i])
        );
    end

    always_comb begin
        w_hit   = 1'b0;
        w_color = '0;
        w_id    = '0;
        for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
            if (w_opaque[i] && !w_hit) begin
                w_hit   = 1'b1;
                w_color = w_colors[i];
                w_id    = SEL_W'(i);
            end
        end
    end

    // A slot collides when it and at least one other slot are opaque together
    always_comb begin
        w_coll_now = '0;
        for (int unsigned i = 0; i < NUM_SPRITES; i++)
            w_coll_now[i] = w_opaque[i] && ((w_opaque & ~(NUM_SPRITES'(1) << i)) != '0);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sprite_hit   <= 1'b0;
            sprite_color <= '0;
            sprite_id    <= '0;
            collision    <= '0;
            r_mask       <= '0;
        end else begin
            sprite_hit   <= w_hit;
            sprite_color <= w_color;
            sprite_id    <= w_id;
            if (next_frame) begin
                collision <= r_mask | w_coll_now;
                r_mask    <= '0;
            end else begin
                r_mask <= r_mask | w_coll_now;
            end
        end
    end

endmodule

// File: tb/tb_p18_multi_sprite_engine.sv
// Scoreboard bench for p18_multi_sprite_engine: the driver applies one input
// set per clock, evaluates a behavioural screen model and queues the expected
// outputs; the monitor compares them after the following rising edge.
module tb_p18_multi_sprite_engine;
    localparam int NS = 4, SW = 12, SH = 12, SC = 3, CB = 11;
    localparam int WS = 100, HS = 75, COLB = 6, SEL_W = 2, DATA_W = 12;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0, active = 1'b0, next_frame = 1'b0, enable_movement = 1'b0;
    logic [CB-1:0]     counter_h = '0, counter_v = '0;
    logic              sprite_hit;
    logic [COLB-1:0]   sprite_color;
    logic [SEL_W-1:0]  sprite_id;
    logic [NS-1:0]     collision;

    p18_multi_sprite_engine_if #(.SEL_W(SEL_W), .DATA_W(DATA_W)) cfg_if ();

    p18_multi_sprite_engine #(
        .NUM_SPRITES(NS), .SPRITE_W(SW), .SPRITE_H(SH), .SCALE_LOG2(SC), .CNT_BITS(CB),
        .WIDTH_SMALL(WS), .HEIGHT_SMALL(HS), .COLOR_BITS(COLB)
    ) dut (
        .clk(clk), .reset_n(reset_n), .active(active),
        .counter_h(counter_h), .counter_v(counter_v),
        .next_frame(next_frame), .enable_movement(enable_movement),
        .cfg(cfg_if),
        .sprite_hit(sprite_hit), .sprite_color(sprite_color),
        .sprite_id(sprite_id), .collision(collision)
    );

    always #5 clk = ~clk;

    // Behavioural model of the sprite registers
    int m_bmp [NS][SH];
    int m_x[NS], m_y[NS], m_shx[NS], m_shy[NS], m_col[NS];
    bit m_en[NS], m_mv[NS], m_dxn[NS], m_dyn[NS];
    int m_mask, m_coll;

    typedef struct { bit hit; int color; int id; int coll; bit ready; } exp_t;
    exp_t q[$];
    int checks = 0, errors = 0;
    bit done = 1'b0;

    function automatic void model_reset();
        for (int s = 0; s < NS; s++) begin
            for (int r = 0; r < SH; r++) m_bmp[s][r] = 0;
            m_x[s] = 8 + 16 * s; m_y[s] = 8 + 8 * s;
            m_shx[s] = m_x[s];   m_shy[s] = m_y[s];
            m_col[s] = 'h3F;
            m_en[s] = 0; m_mv[s] = 0; m_dxn[s] = 0; m_dyn[s] = 0;
        end
        m_mask = 0; m_coll = 0;
    endfunction

    function automatic bit opaque_of(int s, int h, int v, bit act);
        int dh, dv;
        if (!act || !m_en[s]) return 0;
        dh = (h >> SC) - m_x[s];
        dv = (v >> SC) - m_y[s];
        if (dh < 0 || dh >= SW || dv < 0 || dv >= SH) return 0;
        return ((m_bmp[s][dv] >> (SW - 1 - dh)) & 1) != 0;
    endfunction

    // One axis of the bounce rule: step by +-1, or reverse at the limit without moving
    function automatic void bounce(inout int p, inout bit neg, input int lim);
        if (neg) begin
            if (p == 0) neg = 0; else p = p - 1;
        end else begin
            if (p == lim) neg = 1; else p = p + 1;
        end
    endfunction

    function automatic void frame_update(bit mv);
        for (int s = 0; s < NS; s++) begin
            m_x[s] = m_shx[s]; m_y[s] = m_shy[s];
            if (mv && m_en[s] && m_mv[s]) begin
                bounce(m_x[s], m_dxn[s], WS - SW);
                bounce(m_y[s], m_dyn[s], HS - SH);
            end
            m_shx[s] = m_x[s]; m_shy[s] = m_y[s];
        end
    endfunction

    function automatic void cfg_apply(int sel, int addr, int data);
        if (sel >= NS) return;
        if (addr < SH)          m_bmp[sel][addr] = data & 'hFFF;
        else if (addr == SH)    m_shx[sel] = data & 'hFF;
        else if (addr == SH + 1) m_shy[sel] = data & 'hFF;
        else if (addr == SH + 2) m_col[sel] = data & 'h3F;
        else if (addr == SH + 3) begin
            m_en[sel]  = (data & 1) != 0;
            m_mv[sel]  = (data & 2) != 0;
            m_dxn[sel] = (data & 4) != 0;
            m_dyn[sel] = (data & 8) != 0;
        end
    endfunction

    // Drive one cycle of inputs and queue the outputs expected after the next edge
    task automatic step(input int h, input int v, input bit act, input bit nf, input bit mv,
                        input bit rst, input bit cv, input int sel, input int addr, input int data);
        exp_t e;
        int op, n, now;
        @(negedge clk);
        reset_n = !rst; counter_h = CB'(h); counter_v = CB'(v); active = act;
        next_frame = nf; enable_movement = mv;
        cfg_if.valid = cv; cfg_if.sel = SEL_W'(sel); cfg_if.addr = 5'(addr); cfg_if.data = DATA_W'(data);
        op = 0; n = 0;
        for (int s = 0; s < NS; s++)
            if (opaque_of(s, h, v, act)) begin op |= (1 << s); n++; end
        e.ready = !nf; e.hit = 0; e.color = 0; e.id = 0;
        if (rst) begin
            model_reset();
        end else begin
            for (int s = NS - 1; s >= 0; s--)
                if ((op >> s) & 1) begin e.hit = 1; e.color = m_col[s]; e.id = s; end
            now = (n >= 2) ? op : 0;
            if (nf) begin
                m_coll = m_mask | now; m_mask = 0;
                frame_update(mv);
            end else begin
                m_mask |= now;
                if (cv) cfg_apply(sel, addr, data);
            end
        end
        e.coll = m_coll;
        q.push_back(e);
    endtask

    // Pixel biased towards a random slot's bounding box (one pixel margin each side)
    task automatic rand_pix(output int h, output int v);
        int s, hs, vs;
        s = $urandom_range(0, NS - 1);
        if ($urandom_range(0, 1) == 1) begin
            hs = m_x[s] + int'($urandom_range(0, SW + 1)) - 1;
            vs = m_y[s] + int'($urandom_range(0, SH + 1)) - 1;
            if (hs < 0) hs = 0;
            if (vs < 0) vs = 0;
            h = hs * 8 + int'($urandom_range(0, 7));
            v = vs * 8 + int'($urandom_range(0, 7));
        end else begin
            h = $urandom_range(0, 799);
            v = $urandom_range(0, 599);
        end
    endtask

    task automatic rstep(input bit nf, input bit mv, input bit rst, input bit cv,
                         input int sel, input int addr, input int data);
        int h, v;
        rand_pix(h, v);
        step(h, v, $urandom_range(0, 9) != 0, nf, mv, rst, cv, sel, addr, data);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) rstep(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic cfg_wr(input int sel, input int addr, input int data);
        rstep(0, 0, 0, 1, sel, addr, data);
    endtask

    task automatic frame(input bit mv);
        rstep(1, mv, 0, 0, 0, 0, 0);
    endtask

    task automatic pix(input int h, input int v);
        step(h, v, 1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Scan one scaled row across slot s, including a column outside each edge
    task automatic sweep(input int s, input int row);
        for (int c = -1; c <= SW; c++)
            if (m_x[s] + c >= 0) pix((m_x[s] + c) * 8 + 3, (m_y[s] + row) * 8 + 2);
    endtask

    // Monitor: compare queued expectations just after each rising edge
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (sprite_hit !== e.hit || sprite_color !== COLB'(e.color) || sprite_id !== SEL_W'(e.id)) begin
                    errors++;
                    $display("FAIL pixel: got hit=%0d color=%h id=%0d, expected hit=%0d color=%h id=%0d",
                             sprite_hit, sprite_color, sprite_id, e.hit, COLB'(e.color), e.id);
                end
                checks++;
                if (collision !== NS'(e.coll)) begin
                    errors++;
                    $display("FAIL collision: got %b, expected %b", collision, NS'(e.coll));
                end
                checks++;
                if (cfg_if.ready !== e.ready) begin
                    errors++;
                    $display("FAIL cfg_ready: got %0d, expected %0d", cfg_if.ready, e.ready);
                end
            end
        end
    end

    initial begin : watchdog
        #5_000_000;
        if (!done) begin
            $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
            $fatal(1, "watchdog expired");
        end
    end

    initial begin : driver
        int sel, fld, addr, data;
        bit nf, cv;
        cfg_if.valid = 1'b0; cfg_if.sel = '0; cfg_if.addr = '0; cfg_if.data = '0;
        model_reset();

        // Reset state, idle frame with nothing enabled
        repeat (3) rstep(0, 0, 1, 0, 0, 0, 0);
        idle(40); frame(0); idle(20);

        // Slot 0: one full row at (2,1), colour 30
        cfg_wr(0, 0, 'hFFF);
        cfg_wr(0, SH, 2);
        cfg_wr(0, SH + 1, 1);
        cfg_wr(0, SH + 2, 'h30);
        cfg_wr(0, SH + 3, 1);
        idle(5); frame(0);
        pix(16, 8); pix(15, 8); pix(16 + 11 * 8, 8); pix(16 + 12 * 8, 8); pix(16, 16);

        // Slots 0 and 1 fully opaque at the same place
        for (int r = 0; r < SH; r++) begin
            cfg_wr(0, r, 'hFFF);
            cfg_wr(1, r, 'hFFF);
        end
        cfg_wr(1, SH, 2); cfg_wr(1, SH + 1, 1); cfg_wr(1, SH + 2, 'h0C); cfg_wr(1, SH + 3, 1);
        frame(0);
        sweep(0, 0); sweep(0, 5);
        frame(0); idle(10);

        // Slot 1 moving right from the right edge: holds, then walks left
        cfg_wr(1, SH, WS - SW);
        cfg_wr(1, SH + 3, 'b0011);
        frame(0);
        for (int f = 0; f < 4; f++) begin
            frame(1);
            sweep(1, 3);
        end

        // Shadow x write held across next_frame
        step(0, 0, 1, 1, 0, 0, 1, 1, SH, 40);
        step(0, 0, 1, 0, 0, 0, 1, 1, SH, 40);
        sweep(1, 3);
        frame(0);
        sweep(1, 3);

        // Reset mid-frame while slots overlap
        cfg_wr(1, SH, 2); frame(0);
        pix(24, 16); pix(32, 24);
        step(24, 16, 1, 0, 0, 1, 0, 0, 0, 0);
        pix(24, 16);
        cfg_wr(0, 0, 'hFFF); cfg_wr(0, SH + 3, 1);
        sweep(0, 0); frame(0);

        // Randomised configuration, motion and frames
        for (int i = 0; i < 3000; i++) begin
            nf = ($urandom_range(0, 29) == 0);
            cv = ($urandom_range(0, 5) == 0);
            sel = $urandom_range(0, NS - 1);
            fld = $urandom_range(0, 9);
            case (fld)
                0, 1, 2: begin addr = $urandom_range(0, SH - 1); data = $urandom_range(0, 'hFFF); end
                3: begin addr = SH;     data = ($urandom_range(0, 15) << 8) | $urandom_range(0, WS - SW); end
                4: begin addr = SH + 1; data = ($urandom_range(0, 15) << 8) | $urandom_range(0, HS - SH); end
                5: begin addr = SH + 2; data = $urandom_range(0, 'hFFF); end
                6, 7: begin addr = SH + 3; data = $urandom_range(0, 'hFFF); end
                8: begin addr = $urandom_range(SH + 4, 31); data = $urandom_range(0, 'hFFF); end
                default: begin addr = $urandom_range(0, 31); data = $urandom_range(0, 'hFFF); end
            endcase
            rstep(nf, $urandom_range(0, 3) != 0, $urandom_range(0, 499) == 0, cv, sel, addr, data);
            if (nf && cv) rstep(0, 0, 0, 1, sel, addr, data);
        end

        repeat (3) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        done = 1'b1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
